oled_spi_rx: RTL and testbench

OLED_SPI_RX -- requirements
Module: oled_spi_rx

---
 rtl/oled_pkg.sv | 11 +
 rtl/spi_byte_rx.sv | 56 +++++
 rtl/oled_spi_rx.sv | 102 ++++++++++
 tb/tb_oled_spi_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// oled_pkg: shared framebuffer geometry, SSD1306-style command codes and parser states
package oled_pkg;
  localparam int FB_COLS = 128;
  localparam int FB_PAGES = 8;
  localparam int FB_ADDR_W = 10;
  localparam logic [7:0] CMD_COL_ADDR = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [6:0] COL_MAX = 7'(FB_COLS - 1);
  localparam logic [2:0] PAGE_MAX = 3'(FB_PAGES - 1);
  typedef enum logic [2:0] {IDLE, COL_START, COL_END, PG_START, PG_END} parser_state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronizes raw SPI pins into the clock domain and assembles MSB-first bytes.
// Ports: clock/reset (async active-low); spi_sck, spi_mosi, spi_cs_n, spi_dc raw pins;
// byte_valid one-cycle strobe with byte_data and byte_dc (dc sampled with the 8th bit);
// cs_active is the synchronized chip select.
module spi_byte_rx (
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       cs_active
);
  logic [1:0] sck_s, mosi_s, cs_s, dc_s;
  logic       sck_d;
  logic [2:0] cnt;
  logic [6:0] sh;
  logic       rise;
  assign rise = sck_s[1] & ~sck_d;
  assign cs_active = ~cs_s[1];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      sck_s <= 2'b00;
      mosi_s <= 2'b00;
      cs_s <= 2'b11;
      dc_s <= 2'b11;
      sck_d <= 1'b0;
      cnt <= 3'd0;
      sh <= 7'd0;
      byte_valid <= 1'b0;
      byte_data <= 8'd0;
      byte_dc <= 1'b1;
    end else begin
      sck_s <= {sck_s[0], spi_sck};
      mosi_s <= {mosi_s[0], spi_mosi};
      cs_s <= {cs_s[0], spi_cs_n};
      dc_s <= {dc_s[0], spi_dc};
      sck_d <= sck_s[1];
      byte_valid <= 1'b0;
      if (cs_s[1]) begin
        cnt <= 3'd0;
        sh <= 7'd0;
      end else if (rise) begin
        cnt <= cnt + 3'd1;
        sh <= {sh[5:0], mosi_s[1]};
        if (cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data <= {sh, mosi_s[1]};
          byte_dc <= dc_s[1];
        end
      end
    end
endmodule

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: OLED SPI sink that turns display-data bytes into framebuffer byte writes.
// Ports: clock/reset (async active-low); spi_sck/spi_mosi/spi_cs_n/spi_dc raw SPI pins;
// pix_valid/pix_addr/pix_data framebuffer write (addr = page*128 + column);
// frame_start pulses with the write that wraps the pointer to the window origin; busy = CS active.
// Define OLED_CMD_DECODE_EN to decode 0x21/0x22 address-window commands; otherwise the
// window is the full screen and any command byte returns the pointer to 0.
module oled_spi_rx
  import oled_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  input  logic                 spi_cs_n,
  input  logic                 spi_dc,
  output logic                 pix_valid,
  output logic [FB_ADDR_W-1:0] pix_addr,
  output logic [7:0]           pix_data,
  output logic                 frame_start,
  output logic                 busy
);
  logic       byte_valid, byte_dc, cmd, ptr_rst, col_wrap, page_wrap;
  logic [7:0] byte_data;
  logic [6:0] col, col_start, col_end;
  logic [2:0] page, pg_start, pg_end;
  spi_byte_rx u_rx (
    .clock(clock),
    .reset(reset),
    .spi_sck(spi_sck),
    .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n),
    .spi_dc(spi_dc),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_dc(byte_dc),
    .cs_active(busy)
  );
  assign cmd = byte_valid & ~byte_dc;
`ifdef OLED_CMD_DECODE_EN
  parser_state_t state, state_nx;
  always_comb begin
    state_nx = state;
    if (cmd)
      case (state)
        IDLE:      state_nx = byte_data == CMD_COL_ADDR ? COL_START :
                              byte_data == CMD_PAGE_ADDR ? PG_START : IDLE;
        COL_START: state_nx = COL_END;
        PG_START:  state_nx = PG_END;
        default:   state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      col_start <= 7'd0;
      col_end <= COL_MAX;
      pg_start <= 3'd0;
      pg_end <= PAGE_MAX;
    end else begin
      state <= state_nx;
      if (cmd && state == COL_START) col_start <= byte_data[6:0];
      if (cmd && state == COL_END) col_end <= byte_data[6:0];
      if (cmd && state == PG_START) pg_start <= byte_data[2:0];
      if (cmd && state == PG_END) pg_end <= byte_data[2:0];
    end
  // The start registers were written by the previous argument, so they are already valid here.
  assign ptr_rst = cmd && (state == COL_END || state == PG_END);
`else
  assign col_start = 7'd0;
  assign col_end = COL_MAX;
  assign pg_start = 3'd0;
  assign pg_end = PAGE_MAX;
  assign ptr_rst = cmd;
`endif
  assign col_wrap = col == col_end || col == COL_MAX;
  assign page_wrap = page == pg_end || page == PAGE_MAX;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
      pix_addr <= '0;
      pix_data <= 8'd0;
      col <= 7'd0;
      page <= 3'd0;
    end else begin
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
      if (byte_valid && byte_dc) begin
        pix_valid <= 1'b1;
        pix_addr <= {page, col};
        pix_data <= byte_data;
        col <= col_wrap ? col_start : col + 7'd1;
        if (col_wrap) begin
          page <= page_wrap ? pg_start : page + 3'd1;
          frame_start <= page_wrap;
        end
      end else if (ptr_rst) begin
        col <= col_start;
        page <= pg_start;
      end
    end
endmodule

// File: tb/tb_oled_spi_rx.sv
// tb_oled_spi_rx: randomized scoreboard bench for oled_spi_rx with a pointer/window reference model
`timescale 1ns/1ps
module tb_oled_spi_rx;
  logic clock = 1'b0, reset = 1'b0;
  logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1, spi_dc = 1'b1;
  logic pix_valid, frame_start, busy;
  logic [9:0] pix_addr;
  logic [7:0] pix_data;
  int checks = 0, errors = 0, strobes = 0, frames = 0;
  typedef struct {int addr; int data; bit frame; longint t;} exp_t;
  exp_t q[$];
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_cmd, m_arg;
  logic [9:0] last_addr = '0;
  logic [7:0] last_data = '0;

  oled_spi_rx dut (
    .clock(clock), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .spi_dc(spi_dc), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_data(pix_data), .frame_start(frame_start), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      last_addr = '0;
      last_data = '0;
    end else if (pix_valid) begin
      strobes++;
      if (frame_start) frames++;
      if (q.size() == 0) chk("spurious_strobe", {22'd0, pix_addr}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        longint d;
        e = q.pop_front();
        d = $time - e.t;
        chk("pix_addr", 32'(pix_addr), 32'(e.addr));
        chk("pix_data", 32'(pix_data), 32'(e.data));
        chk("frame_start", 32'(frame_start), 32'(e.frame));
        chk("latency_ok", 32'(d > 25 && d <= 55), 32'd1);
      end
      last_addr = pix_addr;
      last_data = pix_data;
    end else begin
      if (frame_start) chk("frame_without_valid", 32'(frame_start), 32'd0);
      if (pix_addr !== last_addr || pix_data !== last_data)
        chk("hold", {14'd0, pix_addr, pix_data}, {14'd0, last_addr, last_data});
    end
  end

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7; m_cmd = 0; m_arg = 0;
  endtask

  task automatic model_byte(input bit dc, input logic [7:0] b);
    exp_t e;
    if (dc) begin
      e.addr = m_page * 128 + m_col;
      e.data = int'(b);
      e.frame = 1'b0;
      e.t = $time;
      if (m_col == m_ce || m_col == 127) begin
        m_col = m_cs;
        if (m_page == m_pe || m_page == 7) begin
          m_page = m_ps;
          e.frame = 1'b1;
        end else m_page++;
      end else m_col++;
      q.push_back(e);
    end else begin
`ifdef OLED_CMD_DECODE_EN
      if (m_cmd == 0) begin
        if (b == 8'h21 || b == 8'h22) begin
          m_cmd = int'(b);
          m_arg = 0;
        end
      end else begin
        if (m_cmd == 'h21) begin
          if (m_arg == 0) m_cs = int'(b) % 128; else m_ce = int'(b) % 128;
        end else begin
          if (m_arg == 0) m_ps = int'(b) % 8; else m_pe = int'(b) % 8;
        end
        if (m_arg == 1) begin
          m_cmd = 0;
          m_col = m_cs;
          m_page = m_ps;
        end else m_arg = 1;
      end
`else
      m_col = 0;
      m_page = 0;
`endif
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      #40 spi_sck = 1'b1;
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input logic [7:0] b);
    spi_dc = dc;
    for (int i = 0; i < 8; i++) begin
      spi_mosi = b[7-i];
      #40 spi_sck = 1'b1;
      if (i == 7) model_byte(dc, b);
      #40 spi_sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    #80;
    chk("busy_active", 32'(busy), 32'd1);
  endtask

  task automatic drain(input int want_strobes);
    repeat (8) @(negedge clock);
    chk("queue_empty", 32'(q.size()), 32'd0);
    if (want_strobes >= 0) chk("strobe_count", 32'(strobes), 32'(want_strobes));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    spi_cs_n = 1'b1;
    spi_sck = 1'b0;
    spi_mosi = 1'b0;
    spi_dc = 1'b1;
    chk("queue_empty_at_reset", 32'(q.size()), 32'd0);
    q.delete();
    repeat (3) @(negedge clock);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    model_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    strobes = 0;
    frames = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clock);
    do_reset();
    // whole-screen sweep from reset
    cs_low();
    for (int i = 0; i < 1024; i++) send_byte(1'b1, 8'(i));
    drain(1024);
    chk("full_frame_count", 32'(frames), 32'd1);
    // reset mid-frame and mid-byte
    for (int i = 0; i < 300; i++) send_byte(1'b1, 8'($urandom));
    drain(1324);
    send_bits(8'($urandom), 3);
    do_reset();
    cs_low();
    send_byte(1'b1, 8'($urandom));
    drain(1);
    // chip-select abort of a partial byte
    do_reset();
    cs_low();
    send_bits(8'($urandom), 5);
    spi_cs_n = 1'b1;
    #160;
    chk("busy_idle", 32'(busy), 32'd0);
    cs_low();
    send_byte(1'b1, 8'hA5);
    drain(1);
    // command bytes never write; 0x21 without arguments
    do_reset();
    cs_low();
    send_byte(1'b0, 8'hAF);
    send_byte(1'b0, 8'h21);
    send_byte(1'b1, 8'($urandom));
    drain(1);
    // address window
    do_reset();
    cs_low();
    send_byte(1'b0, 8'h21);
    send_byte(1'b0, 8'h10);
    send_byte(1'b0, 8'h1F);
    send_byte(1'b0, 8'h22);
    send_byte(1'b0, 8'h02);
    send_byte(1'b0, 8'h03);
    for (int i = 0; i < 40; i++) send_byte(1'b1, 8'($urandom));
    drain(40);
`ifdef OLED_CMD_DECODE_EN
    chk("window_frame_count", 32'(frames), 32'd1);
`else
    chk("window_frame_count", 32'(frames), 32'd0);
`endif
    // page command after data
    do_reset();
    cs_low();
    for (int i = 0; i < 10; i++) send_byte(1'b1, 8'($urandom));
    send_byte(1'b0, 8'h22);
    send_byte(1'b1, 8'($urandom));
    drain(11);
`ifndef OLED_CMD_DECODE_EN
    chk("last_addr_after_cmd", 32'(pix_addr), 32'd0);
`else
    chk("last_addr_after_cmd", 32'(pix_addr), 32'd10);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
